// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IFU/LSU memory-port arbiter: FSM states, owner encoding
// and the bit positions used in the two-way request/grant vectors.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    localparam int GNT_IFU = 0;
    localparam int GNT_LSU = 1;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: a lone requester always wins,
// a tie goes to whichever side was not granted last.
import mem_port_arbiter_pkg::*;

module rr_arb2 (
    input  logic [1:0] valid,
    input  owner_t     last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (valid[GNT_IFU] && valid[GNT_LSU]) begin
            if (last_grant == OWN_IFU) grant[GNT_LSU] = 1'b1;
            else                       grant[GNT_IFU] = 1'b1;
        end else if (valid[GNT_IFU]) begin
            grant[GNT_IFU] = 1'b1;
        end else if (valid[GNT_LSU]) begin
            grant[GNT_LSU] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store with a single
// outstanding transaction, registered downstream request and round-robin grant.
import mem_port_arbiter_pkg::*;

module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_W-1:0]     ifu_addr,
    output logic                  ifu_rsp_valid,
    output logic [DATA_W-1:0]     ifu_rsp_data,
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_W-1:0]     lsu_addr,
    input  logic                  lsu_wen,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_wmask,
    output logic                  lsu_rsp_valid,
    output logic [DATA_W-1:0]     lsu_rsp_data,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_wen,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_W-1:0]     mem_rsp_data,
    output logic                  busy,
    output logic                  err_spurious
);

    state_t     state;
    owner_t     owner;
    owner_t     last_grant;
    logic [1:0] grant;
    logic       idle;
    logic       rsp_hit;

    rr_arb2 u_arb (
        .valid      ({lsu_req_valid, ifu_req_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign idle          = (state == IDLE);
    assign ifu_req_ready = idle && grant[GNT_IFU];
    assign lsu_req_ready = idle && grant[GNT_LSU];
    assign busy          = !idle;

    // Only a response in WAIT_RSP is delivered; anything else is flagged below.
    assign rsp_hit       = (state == WAIT_RSP) && mem_rsp_valid;
    assign ifu_rsp_valid = rsp_hit && (owner == OWN_IFU);
    assign lsu_rsp_valid = rsp_hit && (owner == OWN_LSU);
    assign ifu_rsp_data  = ifu_rsp_valid ? mem_rsp_data : '0;
    assign lsu_rsp_data  = (lsu_rsp_valid && !mem_wen) ? mem_rsp_data : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            owner         <= OWN_IFU;
            last_grant    <= OWN_IFU;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            mem_wen       <= 1'b0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
            err_spurious  <= 1'b0;
        end else begin
            if (mem_rsp_valid && state != WAIT_RSP) err_spurious <= 1'b1;
            case (state)
                IDLE: begin
                    if (grant[GNT_LSU]) begin
                        owner         <= OWN_LSU;
                        last_grant    <= OWN_LSU;
                        mem_addr      <= lsu_addr;
                        mem_wen       <= lsu_wen;
                        mem_wdata     <= lsu_wdata;
                        mem_wmask     <= lsu_wmask;
                        mem_req_valid <= 1'b1;
                        state         <= REQ;
                    end else if (grant[GNT_IFU]) begin
                        owner         <= OWN_IFU;
                        last_grant    <= OWN_IFU;
                        mem_addr      <= ifu_addr;
                        mem_wen       <= 1'b0;
                        mem_wdata     <= '0;
                        mem_wmask     <= '1;
                        mem_req_valid <= 1'b1;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (mem_rsp_valid) state <= IDLE;
                end
                default: begin
                    mem_req_valid <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: grant order, latency, back-pressure,
// spurious-response flag and asynchronous reset.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
    logic [31:0] ifu_addr, ifu_rsp_data;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rsp_data;
    logic [3:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rsp_data;
    logic [3:0]  mem_wmask;
    logic        busy, err_spurious;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .busy(busy), .err_spurious(err_spurious)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From REQ: handshake this cycle, respond next cycle, check the pulse, return to IDLE.
    task automatic respond(input logic [31:0] d, input logic ei, input logic el, input logic [31:0] ed);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("req_valid_drop", mem_req_valid, 1'b0);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = d;
        #1;
        chk("ifu_rsp_valid", ifu_rsp_valid, ei);
        chk("lsu_rsp_valid", lsu_rsp_valid, el);
        if (ei) chk("ifu_rsp_data", ifu_rsp_data, ed);
        else    chk("lsu_rsp_data", lsu_rsp_data, ed);
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        chk("busy_after_rsp", busy, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        ifu_req_valid = 0; ifu_addr = 0;
        lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0;
        #13;
        chk("rst_req_valid", mem_req_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err_spurious, 1'b0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_mask", mem_wmask, 4'h0);
        @(negedge clk) rst = 1'b1;

        // IFU only
        tick();
        ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
        #1;
        chk("ifu_only_ready", ifu_req_ready, 1'b1);
        chk("ifu_only_lsu_ready", lsu_req_ready, 1'b0);
        tick();
        ifu_req_valid = 0;
        chk("ifu_req_valid_n1", mem_req_valid, 1'b1);
        chk("ifu_addr_n1", mem_addr, 32'h8000_0000);
        chk("ifu_wen_n1", mem_wen, 1'b0);
        chk("ifu_mask_n1", mem_wmask, 4'hF);
        chk("ifu_busy", busy, 1'b1);
        respond(32'h0000_0413, 1'b1, 1'b0, 32'h0000_0413);

        // Tie: LSU first (last_grant=IFU), then IFU, then LSU
        ifu_req_valid = 1; ifu_addr = 32'h8000_0004;
        lsu_req_valid = 1; lsu_addr = 32'h1000; lsu_wen = 1; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'h3;
        #1;
        chk("tie1_lsu_ready", lsu_req_ready, 1'b1);
        chk("tie1_ifu_ready", ifu_req_ready, 1'b0);
        tick();
        lsu_wen = 0; lsu_addr = 32'h2000; lsu_wdata = 32'h0; lsu_wmask = 4'hF;
        chk("tie1_addr", mem_addr, 32'h1000);
        chk("tie1_wen", mem_wen, 1'b1);
        chk("tie1_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("tie1_mask", mem_wmask, 4'h3);
        chk("req_ifu_ready0", ifu_req_ready, 1'b0);
        respond(32'h1234_5678, 1'b0, 1'b1, 32'h0);
        chk("tie2_ifu_ready", ifu_req_ready, 1'b1);
        chk("tie2_lsu_ready", lsu_req_ready, 1'b0);
        tick();
        chk("tie2_addr", mem_addr, 32'h8000_0004);
        chk("tie2_mask", mem_wmask, 4'hF);
        respond(32'hAAAA_0001, 1'b1, 1'b0, 32'hAAAA_0001);
        chk("tie3_lsu_ready", lsu_req_ready, 1'b1);
        tick();
        ifu_req_valid = 0; lsu_req_valid = 0;
        chk("tie3_addr", mem_addr, 32'h2000);
        chk("tie3_wen", mem_wen, 1'b0);
        respond(32'h0000_0055, 1'b0, 1'b1, 32'h0000_0055);

        // Back-pressure with changing inputs
        ifu_req_valid = 1; ifu_addr = 32'h100;
        tick();
        lsu_req_valid = 1;
        for (int i = 0; i < 5; i++) begin
            ifu_addr = 32'h200 + i;
            #1;
            chk("bp_req_valid", mem_req_valid, 1'b1);
            chk("bp_addr", mem_addr, 32'h100);
            chk("bp_ifu_ready", ifu_req_ready, 1'b0);
            chk("bp_lsu_ready", lsu_req_ready, 1'b0);
            chk("bp_busy", busy, 1'b1);
            tick();
        end
        ifu_req_valid = 0; lsu_req_valid = 0;
        respond(32'h0BAD_F00D, 1'b1, 1'b0, 32'h0BAD_F00D);

        // Spurious response in IDLE
        mem_rsp_valid = 1; mem_rsp_data = 32'hFFFF_FFFF;
        #1;
        chk("spur_ifu_rsp", ifu_rsp_valid, 1'b0);
        chk("spur_lsu_rsp", lsu_rsp_valid, 1'b0);
        tick();
        mem_rsp_valid = 0;
        chk("spur_err", err_spurious, 1'b1);
        ifu_req_valid = 1; ifu_addr = 32'h300;
        tick();
        ifu_req_valid = 0;
        respond(32'h0000_0777, 1'b1, 1'b0, 32'h0000_0777);
        chk("spur_sticky", err_spurious, 1'b1);

        // Async reset while in WAIT_RSP
        ifu_req_valid = 1; ifu_addr = 32'h400;
        tick();
        ifu_req_valid = 0;
        mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        chk("pre_rst_busy", busy, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_req_valid", mem_req_valid, 1'b0);
        chk("arst_addr", mem_addr, 32'h0);
        chk("arst_mask", mem_wmask, 4'h0);
        chk("arst_err", err_spurious, 1'b0);
        @(negedge clk) rst = 1'b1;
        ifu_req_valid = 1; ifu_addr = 32'h500;
        lsu_req_valid = 1; lsu_addr = 32'h3000; lsu_wen = 0; lsu_wmask = 4'hF;
        #1;
        chk("post_rst_lsu_ready", lsu_req_ready, 1'b1);
        chk("post_rst_ifu_ready", ifu_req_ready, 1'b0);
        tick();
        ifu_req_valid = 0; lsu_req_valid = 0;
        mem_rsp_valid = 1; mem_rsp_data = 32'h0000_4444;
        #1;
        chk("late_rsp_no_pulse", lsu_rsp_valid, 1'b0);
        tick();
        mem_rsp_valid = 0;
        chk("late_rsp_err", err_spurious, 1'b1);
        chk("late_rsp_still_req", mem_req_valid, 1'b1);
        respond(32'h0000_6666, 1'b0, 1'b1, 32'h0000_6666);

        // Lone LSU with last_grant=LSU
        lsu_req_valid = 1; lsu_addr = 32'h3004;
        #1;
        chk("lone_lsu_ready", lsu_req_ready, 1'b1);
        tick();
        lsu_req_valid = 0;
        chk("lone_lsu_addr", mem_addr, 32'h3004);
        respond(32'h0000_9999, 1'b0, 1'b1, 32'h0000_9999);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
